// File: rtl/cart_pkg.sv
// Shared cartridge-side SDRAM constants and the write scheduler state type.
package cart_pkg;

  localparam int unsigned SDRAM_AW   = 25;
  localparam int unsigned SDRAM_DW   = 8;
  localparam int unsigned REQ_LOADER = 0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker over inputs 1..N-1 with an absolute override for input 0.
module rr_arbiter
  import cart_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW:0] w_rank;
  logic [IW:0] w_best;

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_rank  = '0;
    w_best  = '1;
    // Rank is the distance from the pointer in the 1..N-1 rotation; smallest rank wins.
    for (int unsigned j = 1; j < N; j++) begin
      if (i_req[j]) begin
        if ((IW+1)'(j) >= {1'b0, i_ptr})
          w_rank = (IW+1)'(j) - {1'b0, i_ptr};
        else
          w_rank = (IW+1)'(j + N - 1) - {1'b0, i_ptr};
        if (!o_valid || (w_rank < w_best)) begin
          w_best  = w_rank;
          o_idx   = IW'(j);
          o_valid = 1'b1;
        end
      end
    end
    if (i_req[REQ_LOADER]) begin
      o_idx   = IW'(REQ_LOADER);
      o_valid = 1'b1;
    end
  end

endmodule

// File: rtl/sdram_wr_sched.sv
// Shares the single SDRAM write port among cartridge write engines, with a done-pulse watchdog.
module sdram_wr_sched
  import cart_pkg::*;
#(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*SDRAM_AW-1:0] req_addr,
  input  logic [N_REQ*SDRAM_DW-1:0] req_din,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          err,
  input  logic                      err_clr,
  output logic                      busy,
  input  logic                      sdram_ready,
  input  logic                      sdram_done,
  output logic                      sdram_req,
  output logic [SDRAM_AW-1:0]       sdram_addr,
  output logic [SDRAM_DW-1:0]       sdram_din
);

  localparam int unsigned IW  = $clog2(N_REQ);
  localparam int unsigned WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  sched_state_t         r_state, w_state;
  logic [IW-1:0]        r_grant, w_grant;
  logic [IW-1:0]        r_rr, w_rr;
  logic [WDW-1:0]       r_wd, w_wd;
  logic                 r_req, w_req;
  logic [N_REQ-1:0]     r_ack, w_ack;
  logic [N_REQ-1:0]     r_err, w_err;
  logic [SDRAM_AW-1:0]  r_addr, w_addr;
  logic [SDRAM_DW-1:0]  r_din, w_din;

  logic [IW-1:0]        w_arb_idx;
  logic                 w_arb_valid;
  logic [SDRAM_AW-1:0]  w_addr_sel;
  logic [SDRAM_DW-1:0]  w_din_sel;
  logic [N_REQ-1:0]     w_gnt_oh;
  logic                 w_timeout;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_rr),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  always_comb begin
    w_addr_sel = '0;
    w_din_sel  = '0;
    w_gnt_oh   = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (w_arb_idx == IW'(j)) begin
        w_addr_sel = req_addr[j*SDRAM_AW +: SDRAM_AW];
        w_din_sel  = req_din[j*SDRAM_DW +: SDRAM_DW];
      end
      w_gnt_oh[j] = (r_grant == IW'(j));
    end
  end

  assign w_timeout = (TIMEOUT != 0) && (r_wd == WDW'(TIMEOUT));

  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_rr    = r_rr;
    w_wd    = r_wd;
    w_req   = r_req;
    w_ack   = '0;
    w_err   = r_err;
    w_addr  = r_addr;
    w_din   = r_din;
    if (err_clr) w_err = '0;
    unique case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_grant = w_arb_idx;
          w_addr  = w_addr_sel;
          w_din   = w_din_sel;
          if (w_arb_idx != IW'(REQ_LOADER))
            w_rr = (w_arb_idx == IW'(N_REQ - 1)) ? IW'(1) : w_arb_idx + 1'b1;
          w_state = ISSUE;
        end
      end
      ISSUE: begin
        if (sdram_ready) begin
          w_req   = 1'b1;
          w_wd    = '0;
          w_state = WAIT;
        end
      end
      WAIT: begin
        // Done takes precedence over a coincident timeout; a timeout set beats err_clr.
        if (sdram_done) begin
          w_req   = 1'b0;
          w_ack   = w_gnt_oh;
          w_state = IDLE;
        end else if (w_timeout) begin
          w_req   = 1'b0;
          w_ack   = w_gnt_oh;
          w_err   = w_err | w_gnt_oh;
          w_state = IDLE;
        end else if (TIMEOUT != 0) begin
          w_wd = r_wd + 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_rr    <= IW'(1);
      r_wd    <= '0;
      r_req   <= 1'b0;
      r_ack   <= '0;
      r_err   <= '0;
      r_addr  <= '0;
      r_din   <= '0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_rr    <= w_rr;
      r_wd    <= w_wd;
      r_req   <= w_req;
      r_ack   <= w_ack;
      r_err   <= w_err;
      r_addr  <= w_addr;
      r_din   <= w_din;
    end
  end

  assign busy       = (r_state != IDLE);
  assign sdram_req  = r_req;
  assign sdram_addr = r_addr;
  assign sdram_din  = r_din;
  assign ack        = r_ack;
  assign err        = r_err;

endmodule

// File: tb/tb_sdram_wr_sched.sv
// Bench for sdram_wr_sched: directed scenarios then randomized transactions against a transaction-level model.
module tb_sdram_wr_sched;

  localparam int N = 3;
  localparam int T = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*25-1:0] req_addr = '0;
  logic [N*8-1:0]  req_din = '0;
  logic [N-1:0]  ack, err;
  logic          err_clr = 1'b0;
  logic          busy;
  logic          sdram_ready = 1'b0;
  logic          sdram_done = 1'b0;
  logic          sdram_req;
  logic [24:0]   sdram_addr;
  logic [7:0]    sdram_din;

  int n_assert = 0;
  int n_fail   = 0;

  int          rr_m = 1;
  logic [N-1:0] err_m = '0;
  logic [24:0] addr_m [N];
  logic [7:0]  din_m [N];

  sdram_wr_sched #(
    .N_REQ   (N),
    .TIMEOUT (T)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_addr    (req_addr),
    .req_din     (req_din),
    .ack         (ack),
    .err         (err),
    .err_clr     (err_clr),
    .busy        (busy),
    .sdram_ready (sdram_ready),
    .sdram_done  (sdram_done),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_din   (sdram_din)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [24:0] a, input logic [7:0] d);
    addr_m[i] = a;
    din_m[i]  = d;
    req_addr[i*25 +: 25] = a;
    req_din[i*8 +: 8]    = d;
  endtask

  // Loader first; otherwise the first requester met walking 1..N-1 from the rr position.
  function automatic int predict(input logic [N-1:0] r);
    int c;
    if (r[0]) return 0;
    for (int k = 0; k < N - 1; k++) begin
      c = 1 + ((rr_m - 1 + k) % (N - 1));
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Called at a negedge where the DUT is IDLE (or in its ack cycle) with req set for arbitration.
  // dly<0 withholds done so the watchdog fires.
  task automatic do_txn(input int stall, input int dly, input bit drop, input bit clr, input bit scramble);
    int w;
    logic [24:0] ea;
    logic [7:0]  ed;
    logic [N-1:0] oh;
    if (req == '0) req[1] = 1'b1;
    w = predict(req);
    if (w != 0) rr_m = (w == N - 1) ? 1 : w + 1;
    ea = addr_m[w];
    ed = din_m[w];
    oh = '0;
    oh[w] = 1'b1;
    sdram_ready = (stall == 0);
    tick();
    check("grant_busy", busy, 1);
    check("issue_req_low", sdram_req, 0);
    check("ack_one_cycle", ack, 0);
    for (int k = 0; k < stall; k++) begin
      check("stall_req_low", sdram_req, 0);
      check("stall_no_err", err, err_m);
      tick();
    end
    sdram_ready = 1'b1;
    tick();
    check("req_rise", sdram_req, 1);
    check("addr", sdram_addr, ea);
    check("din", sdram_din, ed);
    if (scramble) begin
      set_data(w, 25'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) req[w] = 1'b0;
    end
    if (dly >= 0) begin
      for (int j = 0; j < dly; j++) begin
        check("wait_req", sdram_req, 1);
        check("wait_ack", ack, 0);
        tick();
      end
      check("addr_hold", sdram_addr, ea);
      sdram_done = 1'b1;
      if (clr) err_clr = 1'b1;
      tick();
      sdram_done = 1'b0;
      err_clr = 1'b0;
      if (clr) err_m = '0;
    end else begin
      for (int j = 0; j < T; j++) begin
        check("wait_req", sdram_req, 1);
        check("wait_ack", ack, 0);
        tick();
      end
      check("last_wait_req", sdram_req, 1);
      if (clr) err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      if (clr) err_m = '0;
      err_m = err_m | oh;
    end
    check("ack", ack, oh);
    check("req_drop", sdram_req, 0);
    check("err", err, err_m);
    check("busy_idle", busy, 0);
    if (drop) req[w] = 1'b0;
  endtask

  initial begin
    int w;
    for (int i = 0; i < N; i++) set_data(i, 25'(i * 25'h10101), 8'(i + 8'h30));

    // Reset state
    tick();
    tick();
    check("rst_sdram_req", sdram_req, 0);
    check("rst_addr", sdram_addr, 0);
    check("rst_din", sdram_din, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;

    // 1: single request, done 4 cycles after req
    set_data(1, 25'h0123456, 8'hA5);
    req = 3'b010;
    do_txn(0, 2, 1, 0, 0);
    tick();
    check("t1_ack_gone", ack, 0);
    check("t1_idle", busy, 0);

    // 2: round robin with loader cutting in
    set_data(1, 25'h0000111, 8'h11);
    set_data(2, 25'h0000222, 8'h22);
    req = 3'b110;
    do_txn(0, 1, 0, 0, 0);
    do_txn(0, 0, 0, 0, 0);
    set_data(0, 25'h1000000, 8'h00);
    req[0] = 1'b1;
    do_txn(0, 3, 1, 0, 0);
    do_txn(0, 1, 0, 0, 0);
    do_txn(0, 2, 0, 0, 0);

    // 3: ready stall longer than the watchdog limit
    req = 3'b010;
    do_txn(20, 3, 1, 0, 0);

    // 4: timeout, sticky err, clear, then clear coinciding with a new timeout
    req = 3'b010;
    do_txn(0, -1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_err_sticky", err, err_m);
      check("t4_idle", busy, 0);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    err_m = '0;
    check("t4_err_cleared", err, 0);
    req = 3'b100;
    do_txn(0, -1, 1, 1, 0);
    check("t4_set_wins", err, 3'b100);

    // 5: done coincides with timeout; stray done in IDLE
    req = 3'b010;
    do_txn(0, T, 1, 0, 0);
    sdram_done = 1'b1;
    tick();
    sdram_done = 1'b0;
    check("t5_stray_ack", ack, 0);
    check("t5_stray_busy", busy, 0);
    tick();
    check("t5_stray_ack2", ack, 0);

    // 6: asynchronous reset in WAIT
    req = 3'b010;
    sdram_ready = 1'b1;
    w = predict(req);
    tick();
    tick();
    check("t6_req_rise", sdram_req, 1);
    check("t6_addr", sdram_addr, addr_m[w]);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_req", sdram_req, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ack", ack, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_addr", sdram_addr, 0);
    err_m = '0;
    rr_m = 1;
    tick();
    check("t6_no_ack", ack, 0);
    reset_n = 1'b1;
    do_txn(0, 1, 1, 0, 0);

    // Randomized transactions
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          set_data(i, 25'($urandom), 8'($urandom));
        end
      end
      if (req == '0) req[1 + $urandom_range(0, N - 2)] = 1'b1;
      do_txn(int'($urandom_range(0, 3)),
             ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, T)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_wr_sched.md
Name: sdram_wr_sched

Overview:
- Shares the single SDRAM write port among several cartridge-side write engines: flash program/erase engines, mapper SRAM write-back and the ROM loader.
- Requesters hold a level request with address/data. The block picks one, drives the SDRAM req/ready/done handshake and returns a one-cycle ack to the winner.
- Adds a watchdog so that a lost done pulse cannot hang the cart slot.

Parameters:
- N_REQ, 3, number of requesters (2..8); index 0 is the loader.
- TIMEOUT, 1023, max cycles to wait for sdram_done after sdram_req rises; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester write request, level, held until ack
- req_addr  in  N_REQ*25  packed SDRAM byte addresses, slice i = [25*i+24:25*i]
- req_din  in  N_REQ*8  packed write data, slice i = [8*i+7:8*i]
- ack  out  N_REQ  one-hot, 1-cycle pulse: write of requester i completed or aborted
- err  out  N_REQ  sticky timeout flag per requester; cleared by err_clr
- err_clr  in  1  clears all err bits
- busy  out  1  high while not IDLE
- sdram_ready  in  1  SDRAM controller can accept a request
- sdram_done  in  1  1-cycle completion pulse from SDRAM controller
- sdram_req  out  1  write request, held until done or timeout
- sdram_addr  out  25  latched address of the granted requester
- sdram_din  out  8  latched data of the granted requester

Behaviour:
- Reset values: sdram_req=0, sdram_addr=0, sdram_din=0, ack=0, err=0, busy=0, state=IDLE, rr pointer=1 (or 0 when N_REQ=1), watchdog=0.
- State machine:
  - IDLE: if any req, arbitrate. Latch grant index, addr and din into sdram_addr/sdram_din, then go to ISSUE. Arbitration and latch take one cycle.
  - ISSUE: when sdram_ready=1, assert sdram_req next edge, clear watchdog, go to WAIT. If sdram_ready=0, stay; the watchdog does not run in ISSUE.
  - WAIT: sdram_req held at 1, watchdog increments each cycle.
    - On sdram_done: drop sdram_req, pulse ack[grant], go to IDLE.
    - Else if TIMEOUT!=0 and watchdog==TIMEOUT: drop sdram_req, set err[grant], pulse ack[grant], go to IDLE.
- Arbitration:
  - req[0] (loader) has absolute priority.
  - Among 1..N_REQ-1: round-robin starting at rr pointer. After each grant to i>=1, rr = i+1, wrapping from N_REQ-1 to 1.
  - The rr pointer is unchanged by grants to 0.
- Latency: req seen in IDLE with sdram_ready=1 gives sdram_req 2 cycles later. sdram_done gives ack in the next cycle. Next grant no earlier than the cycle after ack (IDLE bubble of 1 cycle).
- Requester deasserting req after grant but before ack: transaction still completes and ack is still pulsed. Addr/data are latched, so later changes are ignored.
- sdram_done while not in WAIT: ignored.
- sdram_done and timeout in the same cycle: done wins, err not set.
- err_clr and a new timeout in the same cycle: set wins.
- Requester holding req after ack: treated as a new request at the next arbitration.
- Watchdog width: clog2(TIMEOUT+1). It saturates only by exiting WAIT, never wraps.
- Asynchronous reset mid-transaction: all outputs return to reset values immediately. sdram_req drops; no ack is issued for the aborted write.

Decomposition:
- Shared package cart_pkg:
  - SDRAM_AW=25, SDRAM_DW=8;
  - state enum sched_state_t {IDLE, ISSUE, WAIT};
  - requester index constant REQ_LOADER=0.
- One sub-module, rr_arbiter: N-input round-robin picker with a priority-0 override, a pointer input and grant-index/valid outputs; purely combinational. The scheduler owns the pointer register.

Test Plan:
1. Single request: req=3'b010, addr=25'h0123456, din=8'hA5, sdram_ready=1, done 4 cycles after req. Expect sdram_req asserted 2 cycles after req with sdram_addr=25'h0123456 and sdram_din=8'hA5, then ack=3'b010 for exactly 1 cycle after done.
2. Round-robin: req=3'b110 held continuously, done returned each time. Expect grant order 1,2,1,2. With req[0] raised mid-sequence, 0 is granted next, then the sequence resumes at the pending rr position.
3. Ready stall: sdram_ready=0 for 20 cycles after grant. Expect sdram_req=0 throughout and no err even with TIMEOUT=8; sdram_req rises the cycle after ready=1.
4. Timeout: TIMEOUT=8, no sdram_done. Expect sdram_req to drop after 8 WAIT cycles, err[1]=1 and ack[1] pulsed; err stays set until err_clr, then 0.
5. Done and timeout coincide on cycle TIMEOUT. Expect ack pulsed and err=0. A stray sdram_done in IDLE produces no ack.
6. Assert reset_n=0 in WAIT. Expect sdram_req=0 and busy=0 asynchronously with no ack; after release, a held req is re-granted from IDLE.
